// File: rtl/eq_band_mixer.sv
// Three-band gain/sum/saturate stage for the graphic equalizer, one shared multiplier.
// Optional macro EQ_GAIN_RAMP_EN: per-band effective gains slew one LSB per sample toward the targets.
module eq_band_mixer #(
  parameter int DATA_WIDTH = 32,
  parameter int GAIN_WIDTH = 8,
  parameter int ACC_WIDTH  = DATA_WIDTH + GAIN_WIDTH + 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] bass_in,
  input  logic signed [DATA_WIDTH-1:0] mid_in,
  input  logic signed [DATA_WIDTH-1:0] treble_in,
  input  logic                         sample_valid,
  output logic                         in_ready,
  input  logic        [GAIN_WIDTH-1:0] bass_gain,
  input  logic        [GAIN_WIDTH-1:0] mid_gain,
  input  logic        [GAIN_WIDTH-1:0] treble_gain,
  output logic signed [DATA_WIDTH-1:0] d_out,
  output logic                         out_valid,
  output logic                         overrun,
  input  logic                         overrun_clr
);

  localparam int NB = 3;
  localparam logic [GAIN_WIDTH-1:0] UNITY_GAIN = GAIN_WIDTH'(16);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MAC_B, MAC_M, MAC_T, DONE} state_t;

  state_t state_reg, state_next;

  logic signed [DATA_WIDTH-1:0] band_in     [NB];
  logic        [GAIN_WIDTH-1:0] target_gain [NB];
  logic        [GAIN_WIDTH-1:0] accept_gain [NB];
  logic signed [DATA_WIDTH-1:0] sample_reg  [NB];
  logic        [GAIN_WIDTH-1:0] gain_reg    [NB];

  logic                         accept;
  logic [1:0]                   band_sel;
  logic signed [DATA_WIDTH-1:0] sel_sample;
  logic        [GAIN_WIDTH-1:0] sel_gain;
  logic signed [ACC_WIDTH-1:0]  mul_a;
  logic signed [ACC_WIDTH-1:0]  mul_b;
  logic signed [ACC_WIDTH-1:0]  product;
  logic signed [ACC_WIDTH-1:0]  acc_reg;
  logic signed [ACC_WIDTH-1:0]  acc_shift;
  logic signed [DATA_WIDTH-1:0] sat_value;

  assign band_in[0]     = bass_in;
  assign band_in[1]     = mid_in;
  assign band_in[2]     = treble_in;
  assign target_gain[0] = bass_gain;
  assign target_gain[1] = mid_gain;
  assign target_gain[2] = treble_gain;

  assign in_ready = (state_reg == IDLE);
  assign accept   = sample_valid && in_ready;

`ifdef EQ_GAIN_RAMP_EN
  logic [GAIN_WIDTH-1:0] eff_gain_reg  [NB];
  logic [GAIN_WIDTH-1:0] eff_gain_next [NB];

  // The MAC uses the gain as it stood at accept; the slew takes effect on the next sample.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_ramp
      assign accept_gain[gi]   = eff_gain_reg[gi];
      assign eff_gain_next[gi] =
        (eff_gain_reg[gi] < target_gain[gi]) ? eff_gain_reg[gi] + GAIN_WIDTH'(1) :
        (eff_gain_reg[gi] > target_gain[gi]) ? eff_gain_reg[gi] - GAIN_WIDTH'(1) :
                                               eff_gain_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) eff_gain_reg[i] <= UNITY_GAIN;
    end else if (accept) begin
      for (int i = 0; i < NB; i++) eff_gain_reg[i] <= eff_gain_next[i];
    end
  end
`else
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_direct
      assign accept_gain[gi] = target_gain[gi];
    end
  endgenerate
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        sample_reg[i] <= '0;
        gain_reg[i]   <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < NB; i++) begin
        sample_reg[i] <= band_in[i];
        gain_reg[i]   <= accept_gain[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    band_sel   = 2'd0;
    case (state_reg)
      IDLE:    if (sample_valid) state_next = MAC_B;
      MAC_B:   begin band_sel = 2'd0; state_next = MAC_M; end
      MAC_M:   begin band_sel = 2'd1; state_next = MAC_T; end
      MAC_T:   begin band_sel = 2'd2; state_next = DONE;  end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sample is sign-extended, gain zero-extended, so the shared product stays exact.
  assign sel_sample = sample_reg[band_sel];
  assign sel_gain   = gain_reg[band_sel];
  assign mul_a      = {{(ACC_WIDTH-DATA_WIDTH){sel_sample[DATA_WIDTH-1]}}, sel_sample};
  assign mul_b      = {{(ACC_WIDTH-GAIN_WIDTH){1'b0}}, sel_gain};
  assign product    = mul_a * mul_b;
  assign acc_shift  = acc_reg >>> 4;

  always_comb begin
    sat_value = acc_shift[DATA_WIDTH-1:0];
    if (acc_shift > SAT_MAX)      sat_value = SAT_MAX[DATA_WIDTH-1:0];
    else if (acc_shift < SAT_MIN) sat_value = SAT_MIN[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg   <= '0;
      d_out     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_reg)
        MAC_B:   acc_reg <= product;
        MAC_M:   acc_reg <= acc_reg + product;
        MAC_T:   acc_reg <= acc_reg + product;
        DONE: begin
          d_out     <= sat_value;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
      // A dropped sample beats a simultaneous clear.
      if (sample_valid && !in_ready) overrun <= 1'b1;
      else if (overrun_clr)          overrun <= 1'b0;
    end
  end

endmodule
